// File: rtl/filter_mul_share_arbiter_if.sv
// Bundle of requester, shared-multiplier and response signals for the filter multiplier arbiter.
// The master side is the requesters, the multiplier and the result consumer. The slave side is the arbiter.
interface filter_mul_share_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int A_W     = 8,
    parameter int B_W     = 22,
    parameter int P_W     = 29
);
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ*A_W-1:0] req_a;
    logic [NUM_REQ*B_W-1:0] req_b;
    logic [NUM_REQ-1:0]     req_ready;
    logic [A_W-1:0]         mul_din0;
    logic [B_W-1:0]         mul_din1;
    logic [P_W-1:0]         mul_dout;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [P_W-1:0]         rsp_p;
    logic [ID_W-1:0]        rsp_id;

    modport master (
        output req_valid, req_a, req_b, mul_dout, rsp_ready,
        input  req_ready, mul_din0, mul_din1, rsp_valid, rsp_p, rsp_id
    );

    modport slave (
        input  req_valid, req_a, req_b, mul_dout, rsp_ready,
        output req_ready, mul_din0, mul_din1, rsp_valid, rsp_p, rsp_id
    );
endinterface

// File: rtl/filter_mul_share_arbiter.sv
// Round-robin sequencer that shares one combinational multiplier among NUM_REQ requesters.
// The operands are registered onto the multiplier inputs, and the product is captured with the requester ID.
module filter_mul_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int A_W     = 8,
    parameter int B_W     = 22,
    parameter int P_W     = 29
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst,
    filter_mul_share_arbiter_if.slave    bus
);
    logic [ID_W-1:0]    r_last_grant;
    logic               r_vld_p1;
    logic [ID_W-1:0]    r_id_p1;
    logic [A_W-1:0]     r_a_p1;
    logic [B_W-1:0]     r_b_p1;
    logic               r_vld_p2;
    logic [ID_W-1:0]    r_id_p2;
    logic [P_W-1:0]     r_p_p2;

    logic               w_adv1;
    logic               w_adv2;
    logic               w_hi_found;
    logic               w_lo_found;
    logic [ID_W-1:0]    w_hi_id;
    logic [ID_W-1:0]    w_lo_id;
    logic               w_found;
    logic [ID_W-1:0]    w_win_id;
    logic               w_xfer;
    logic [NUM_REQ-1:0] w_ready;
    logic [A_W-1:0]     w_a;
    logic [B_W-1:0]     w_b;

    assign w_adv2 = !r_vld_p2 || bus.rsp_ready;
    assign w_adv1 = !r_vld_p1 || w_adv2;

    // Rotating priority: the lowest index above last_grant wins, otherwise the lowest index at or below it.
    always_comb begin
        w_hi_found = 1'b0;
        w_lo_found = 1'b0;
        w_hi_id    = '0;
        w_lo_id    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req_valid[i]) begin
                if (ID_W'(i) > r_last_grant) begin
                    w_hi_found = 1'b1;
                    w_hi_id    = ID_W'(i);
                end else begin
                    w_lo_found = 1'b1;
                    w_lo_id    = ID_W'(i);
                end
            end
        end
    end

    assign w_found  = w_hi_found || w_lo_found;
    assign w_win_id = w_hi_found ? w_hi_id : w_lo_id;
    assign w_xfer   = w_found && w_adv1 && !ap_rst;

    always_comb begin
        w_ready = '0;
        w_a     = '0;
        w_b     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win_id == ID_W'(i)) begin
                w_ready[i] = w_xfer;
                w_a        = bus.req_a[i*A_W +: A_W];
                w_b        = bus.req_b[i*B_W +: B_W];
            end
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_last_grant <= ID_W'(NUM_REQ - 1);
            r_vld_p1     <= 1'b0;
            r_id_p1      <= '0;
            r_a_p1       <= '0;
            r_b_p1       <= '0;
            r_vld_p2     <= 1'b0;
            r_id_p2      <= '0;
            r_p_p2       <= '0;
        end else begin
            // Stage p1: operand registers feeding the shared multiplier
            if (w_xfer) begin
                r_a_p1       <= w_a;
                r_b_p1       <= w_b;
                r_id_p1      <= w_win_id;
                r_vld_p1     <= 1'b1;
                r_last_grant <= w_win_id;
            end else if (w_adv1) begin
                r_vld_p1     <= 1'b0;
            end
            // Stage p2: product capture, held while the consumer stalls
            if (w_adv2 && r_vld_p1) begin
                r_p_p2   <= bus.mul_dout;
                r_id_p2  <= r_id_p1;
                r_vld_p2 <= 1'b1;
            end else if (bus.rsp_ready) begin
                r_vld_p2 <= 1'b0;
            end
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.mul_din0  = r_a_p1;
    assign bus.mul_din1  = r_b_p1;
    assign bus.rsp_valid = r_vld_p2;
    assign bus.rsp_id    = r_id_p2;
    assign bus.rsp_p     = r_p_p2;
endmodule

// File: tb/tb_filter_mul_share_arbiter.sv
// Scoreboard bench for filter_mul_share_arbiter. The stimulus pushes the expected responses and a monitor pops them on each rsp handshake.
// The bench models the shared multiplier as a truncated product.
module tb_filter_mul_share_arbiter;
    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int A_W     = 8;
    localparam int B_W     = 22;
    localparam int P_W     = 29;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [P_W-1:0]  p;
    } exp_t;

    logic ap_clk = 1'b0;
    logic ap_rst;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    int   op_a[NUM_REQ];
    int   op_b[NUM_REQ];
    int   t5_g[9] = '{0, 1, -1, -1, -1, 2, 3, 0, 1};

    filter_mul_share_arbiter_if #(
        .NUM_REQ(NUM_REQ), .ID_W(ID_W), .A_W(A_W), .B_W(B_W), .P_W(P_W)
    ) bus ();

    logic [A_W+B_W-1:0] w_full;
    assign w_full       = (A_W+B_W)'(bus.mul_din0) * (A_W+B_W)'(bus.mul_din1);
    assign bus.mul_dout = w_full[P_W-1:0];

    filter_mul_share_arbiter #(
        .NUM_REQ(NUM_REQ), .ID_W(ID_W), .A_W(A_W), .B_W(B_W), .P_W(P_W)
    ) dut (
        .ap_clk (ap_clk),
        .ap_rst (ap_rst),
        .bus    (bus)
    );

    always #5 ap_clk = ~ap_clk;

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(negedge ap_clk) begin
        if (!ap_rst && bus.rsp_valid && bus.rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("rsp_id", 32'(bus.rsp_id), 32'(mon_e.id));
                check("rsp_p", 32'(bus.rsp_p), 32'(mon_e.p));
            end
        end
    end

    task automatic set_op(input int i, input int a, input int b);
        op_a[i] = a;
        op_b[i] = b;
        bus.req_a[i*A_W +: A_W] = A_W'(a);
        bus.req_b[i*B_W +: B_W] = B_W'(b);
    endtask

    task automatic push_exp(input int id, input int p);
        exp_t e;
        e.id = ID_W'(id);
        e.p  = P_W'(p);
        exp_q.push_back(e);
    endtask

    task automatic push_op(input int id);
        longint full;
        full = longint'(op_a[id]) * longint'(op_b[id]);
        push_exp(id, int'(full % (64'd1 << P_W)));
    endtask

    task automatic next();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic chk_ready(input logic [NUM_REQ-1:0] exp, input string name);
        @(negedge ap_clk);
        check(name, 32'(bus.req_ready), 32'(exp));
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 30 && exp_q.size() != 0; k++) @(posedge ap_clk);
        check(name, 32'(exp_q.size()), 32'd0);
        #1;
    endtask

    initial begin
        ap_rst        = 1'b1;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) set_op(i, i + 1, 100 * (i + 1));
        bus.req_valid = '1;

        repeat (2) @(posedge ap_clk);
        #1;
        @(negedge ap_clk);
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_p", 32'(bus.rsp_p), 32'd0);
        check("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
        check("rst_din0", 32'(bus.mul_din0), 32'd0);
        check("rst_din1", 32'(bus.mul_din1), 32'd0);
        next();
        ap_rst = 1'b0;

        // T2: all requesters valid from reset
        for (int c = 0; c < 8; c++) begin
            chk_ready(NUM_REQ'(1 << (c % NUM_REQ)), "t2_ready");
            push_op(c % NUM_REQ);
            next();
        end
        bus.req_valid = '0;

        // T3: wrap-around from last_grant=3
        set_op(0, 7, 11);
        set_op(2, 9, 13);
        bus.req_valid = 4'b0101;
        chk_ready(4'b0001, "t3_ready_first");
        push_op(0);
        next();
        bus.req_valid = 4'b0100;
        chk_ready(4'b0100, "t3_ready_second");
        push_op(2);
        next();
        bus.req_valid = '0;

        // T4: product overflow truncation
        set_op(3, 255, 4194303);
        bus.req_valid = 4'b1000;
        chk_ready(4'b1000, "t4_ready");
        push_exp(3, 532676353);
        next();
        bus.req_valid = '0;
        drain("t4_drain");

        // T5: backpressure
        for (int i = 0; i < NUM_REQ; i++) set_op(i, 10 + i, 1000 + i);
        bus.req_valid = '1;
        for (int c = 0; c < 9; c++) begin
            bus.rsp_ready = (c >= 5);
            chk_ready((t5_g[c] < 0) ? 4'b0000 : NUM_REQ'(1 << t5_g[c]), "t5_ready");
            if (t5_g[c] >= 0) push_op(t5_g[c]);
            if (c >= 2 && c <= 4) begin
                check("t5_hold_valid", 32'(bus.rsp_valid), 32'd1);
                check("t5_hold_id", 32'(bus.rsp_id), 32'd0);
                check("t5_hold_p", 32'(bus.rsp_p), 32'd10000);
            end
            next();
        end
        bus.req_valid = '0;
        drain("t5_drain");

        // T1: single transfer latency
        set_op(1, 3, 1000);
        bus.req_valid = 4'b0010;
        chk_ready(4'b0010, "t1_ready");
        push_exp(1, 3000);
        next();
        bus.req_valid = '0;
        @(negedge ap_clk);
        check("t1_valid_early", 32'(bus.rsp_valid), 32'd0);
        @(negedge ap_clk);
        check("t1_valid", 32'(bus.rsp_valid), 32'd1);
        check("t1_p", 32'(bus.rsp_p), 32'd3000);
        next();
        drain("t1_drain");

        // T6: reset with S1 and S2 full
        for (int i = 0; i < NUM_REQ; i++) set_op(i, 10 + i, 1000 + i);
        bus.rsp_ready = 1'b0;
        bus.req_valid = '1;
        chk_ready(4'b0100, "t6_fill0");
        next();
        chk_ready(4'b1000, "t6_fill1");
        next();
        ap_rst = 1'b1;
        chk_ready(4'b0000, "t6_rst_ready");
        next();
        ap_rst = 1'b0;
        exp_q.delete();
        @(negedge ap_clk);
        check("t6_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("t6_din0", 32'(bus.mul_din0), 32'd0);
        check("t6_din1", 32'(bus.mul_din1), 32'd0);
        check("t6_ready_after", 32'(bus.req_ready), 32'b0001);
        push_op(0);
        next();
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        drain("t6_drain");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
